register_file_16x32: RTL and testbench

REGISTER_FILE_16X32 -- requirements
Module: register_file_16x32

---
 rtl/register_file_16x32.sv | 91 +++++++++
 tb/tb_register_file_16x32.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_16x32.sv
// Sixteen-entry register file with three combinational read ports, one-hot write
// select, and R15 doubling as a program counter that can auto-increment.
module register_file_16x32 #(
  parameter int WIDTH   = 32,
  parameter int PC_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [15:0]      ld,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pc_inc,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] qc,
  output logic [WIDTH-1:0] pc,
  output logic             ld_err,
  output logic [7:0]       wr_count
);

  localparam int PC_IDX = 15;

  logic [WIDTH-1:0] regs_q [16];
  logic [WIDTH-1:0] regs_d [16];
  logic             ld_err_q, ld_err_d;
  logic [7:0]       wr_count_q, wr_count_d;

  logic ld_any;
  logic ld_one_hot;
  logic commit;

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign ld_any     = (ld != 16'h0000);
  assign ld_one_hot = ld_any && ((ld & (ld - 16'd1)) == 16'h0000);
  assign commit     = we && ld_one_hot;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    regs_d     = regs_q;
    ld_err_d   = ld_err_q;
    wr_count_d = wr_count_q;

    if (pc_inc) begin
      regs_d[PC_IDX] = regs_q[PC_IDX] + WIDTH'(PC_STEP);
    end

    // Applied after the increment so that an explicit write to R15 overrides it.
    if (commit) begin
      for (int i = 0; i < 16; i++) begin
        if (ld[i]) begin
          regs_d[i] = wdata;
        end
      end
      wr_count_d = wr_count_q + 8'd1;
    end

    if (we && ld_any && !ld_one_hot) begin
      ld_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the register array is reset deliberately; the architecture requires
      // every register to read zero after reset, which rules out a RAM macro.
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      ld_err_q   <= 1'b0;
      wr_count_q <= 8'd0;
    end else begin
      regs_q     <= regs_d;
      ld_err_q   <= ld_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign qa       = regs_q[ra];
  assign qb       = regs_q[rb];
  assign qc       = regs_q[rc];
  assign pc       = regs_q[PC_IDX];
  assign ld_err   = ld_err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_register_file_16x32.sv
// Scoreboard bench for register_file_16x32: the driver pushes the outputs a
// reference model predicts, and a monitor pops and compares them each cycle.
module tb_register_file_16x32;

  logic        clk;
  logic        reset;
  logic        we;
  logic [15:0] ld;
  logic [31:0] wdata;
  logic        pc_inc;
  logic [3:0]  ra, rb, rc;
  logic [31:0] qa, qb, qc, pc;
  logic        ld_err;
  logic [7:0]  wr_count;

  register_file_16x32 #(.WIDTH(32), .PC_STEP(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .ld       (ld),
    .wdata    (wdata),
    .pc_inc   (pc_inc),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .qa       (qa),
    .qb       (qb),
    .qc       (qc),
    .pc       (pc),
    .ld_err   (ld_err),
    .wr_count (wr_count)
  );

  typedef struct {
    logic [31:0] qa, qb, qc, pc;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model: architectural state only.
  logic [31:0] m_reg [16];
  logic        m_err;
  int          m_cnt;

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable at the falling edge, between drive and commit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("qa", qa, e.qa);
        check("qb", qb, e.qb);
        check("qc", qc, e.qc);
        check("pc", pc, e.pc);
        check("ld_err", {31'b0, ld_err}, {31'b0, e.err});
        check("wr_count", {24'b0, wr_count}, {24'b0, e.cnt});
      end
    end
  end

  // Drive one cycle, predict the outputs visible before the edge, then advance
  // the model by the architectural rules for that edge.
  task automatic step(input logic rst, input logic w, input logic [15:0] l,
                      input logic [31:0] d, input logic inc,
                      input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input bit push = 1'b1);
    exp_t e;
    int   bits;
    int   idx;
    reset = rst; we = w; ld = l; wdata = d; pc_inc = inc; ra = a; rb = b; rc = c;
    if (push) begin
      e.qa = m_reg[a]; e.qb = m_reg[b]; e.qc = m_reg[c]; e.pc = m_reg[15];
      e.err = m_err; e.cnt = 8'(m_cnt);
      sb.push_back(e);
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      bits = $countones(l);
      idx  = -1;
      if (w && bits == 1) begin
        for (int i = 0; i < 16; i++) if (l[i]) idx = i;
      end
      if (inc && idx != 15) m_reg[15] = m_reg[15] + 32'd4;
      if (idx >= 0) begin
        m_reg[idx] = d;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (w && bits > 1) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, a, b, c);
  endtask

  initial begin
    logic [15:0] rl;
    // Outputs are undefined until the first reset edge, so nothing is pushed here.
    step(1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd15);
    idle(4'd3, 4'd9, 4'd15);

    // One-hot sweep, then read every register back on all three ports.
    for (int n = 0; n < 16; n++)
      step(1'b0, 1'b1, 16'(1 << n), 32'h100 + 32'(n), 1'b0, 4'(n), 4'(n), 4'(n));
    for (int n = 0; n < 16; n++) idle(4'(n), 4'(n), 4'(n));

    // Two-hot select: no write, sticky error one cycle later.
    step(1'b0, 1'b1, 16'h0003, 32'hDEADBEEF, 1'b0, 4'd0, 4'd1, 4'd15);
    idle(4'd0, 4'd1, 4'd2);
    step(1'b0, 1'b1, 16'h0000, 32'h12345678, 1'b0, 4'd0, 4'd1, 4'd2);
    idle(4'd0, 4'd1, 4'd2);

    // PC wraps modulo 2^32.
    step(1'b0, 1'b1, 16'h8000, 32'hFFFFFFF8, 1'b0, 4'd15, 4'd15, 4'd15);
    repeat (3) step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 4'd15, 4'd0, 4'd15);
    idle(4'd15, 4'd15, 4'd15);

    // Write to R15 beats the increment; write to another register does not.
    step(1'b0, 1'b1, 16'h8000, 32'h40, 1'b1, 4'd15, 4'd15, 4'd15);
    step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 4'd15, 4'd15, 4'd15);
    step(1'b0, 1'b1, 16'h0008, 32'hA5A5A5A5, 1'b1, 4'd3, 4'd15, 4'd15);
    idle(4'd3, 4'd15, 4'd15);

    // Read-during-write returns the old value.
    step(1'b0, 1'b1, 16'h0020, 32'h11, 1'b0, 4'd5, 4'd5, 4'd5);
    step(1'b0, 1'b1, 16'h0020, 32'h22, 1'b0, 4'd5, 4'd5, 4'd5);
    idle(4'd5, 4'd5, 4'd5);

    // Reset discards a simultaneous write and increment.
    step(1'b1, 1'b1, 16'h0004, 32'h77, 1'b1, 4'd2, 4'd2, 4'd15);
    idle(4'd2, 4'd2, 4'd15);

    // we=0 ignores an illegal select entirely.
    step(1'b0, 1'b0, 16'hFFFF, 32'h55, 1'b0, 4'd0, 4'd1, 4'd2);
    idle(4'd0, 4'd1, 4'd2);

    // Write counter wraps 255 -> 0.
    for (int n = 0; n < 258; n++)
      step(1'b0, 1'b1, 16'(1 << (n % 15)), 32'(n), 1'b0, 4'(n % 16), 4'd14, 4'd15);
    idle(4'd0, 4'd1, 4'd15);

    // Randomized traffic, mostly legal writes with occasional resets.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       rl = 16'h0000;
        1:       rl = 16'($urandom);
        default: rl = 16'(1 << $urandom_range(0, 15));
      endcase
      step(($urandom_range(0, 59) == 0), 1'($urandom), rl, $urandom, 1'($urandom),
           4'($urandom), 4'($urandom), 4'($urandom));
    end
    idle(4'd15, 4'd0, 4'd7);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
